// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_MD_WAIT  = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    // A load in EX whose destination feeds a live source of the ID instruction; x0 never counts.
    function automatic logic load_use_hit(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       use_rs1,
        input logic       use_rs2
    );
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((use_rs1 && (ex_rd == id_rs1)) || (use_rs2 && (ex_rd == id_rs2)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Operand forwarding select for one EX source register; the younger EX/MEM result wins.
module pipeline_hazard_ctrl_fwd_select
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_sel
);

    // Priority select between the two in-flight writers
    always_comb begin
        fwd_sel = FWD_REGFILE;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
            fwd_sel = FWD_EXMEM;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
            fwd_sel = FWD_MEMWB;
        end else begin
            fwd_sel = FWD_REGFILE;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller around EX: forwarding selects, load-use stall, branch flush and mul/div hold.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_md_start,
    input  logic             md_done,
    input  logic             branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_RegWrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_RegWrite,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic             ex_mem_bubble,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int TMR_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] MD_TIMEOUT_V = TMR_W'(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_e        state_r;
    logic [TMR_W-1:0] timer_r;
    logic             load_use_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    pipeline_hazard_ctrl_fwd_select u_fwd_a (
        .ex_rs         (ex_rs1),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_RegWrite),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_RegWrite),
        .fwd_sel       (forward_a)
    );

    pipeline_hazard_ctrl_fwd_select u_fwd_b (
        .ex_rs         (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_RegWrite),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_RegWrite),
        .fwd_sel       (forward_b)
    );

    assign load_use_s = load_use_hit(ex_MemRead, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);

    // Pipeline enables/bubbles decoded from the current state and this cycle's hazards
    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_hold        = 1'b0;
        ex_mem_bubble  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (ex_md_start && !md_done) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    ex_hold        = 1'b1;
                    ex_mem_bubble  = 1'b1;
                end else if (load_use_s) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                end else begin
                    pc_write_en = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                // The timeout cycle still holds; release happens from RUN next cycle
                if (!md_done) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    ex_hold        = 1'b1;
                    ex_mem_bubble  = 1'b1;
                end else begin
                    pc_write_en = 1'b1;
                end
            end
            ST_LD_STALL: begin
                pc_write_en = 1'b1;
            end
            default: begin
                pc_write_en = 1'b1;
            end
        endcase
    end

    // Controller state, mul/div watchdog, sticky timeout flag and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            timer_r     <= {TMR_W{1'b0}};
            md_timeout  <= 1'b0;
            stall_count <= {CNT_W{1'b0}};
            flush_count <= {CNT_W{1'b0}};
        end else begin
            if (!pc_write_en) begin
                stall_count <= sat_inc(stall_count);
            end else begin
                stall_count <= stall_count;
            end
            if (if_id_flush) begin
                flush_count <= sat_inc(flush_count);
            end else begin
                flush_count <= flush_count;
            end
            case (state_r)
                ST_RUN: begin
                    if (branch_taken) begin
                        state_r <= ST_RUN;
                    end else if (ex_md_start && !md_done) begin
                        state_r <= ST_MD_WAIT;
                        timer_r <= TMR_W'(1);
                    end else if (load_use_s) begin
                        state_r <= ST_LD_STALL;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_LD_STALL: begin
                    state_r <= ST_RUN;
                end
                ST_MD_WAIT: begin
                    if (md_done) begin
                        state_r <= ST_RUN;
                    end else if (timer_r == MD_TIMEOUT_V) begin
                        md_timeout <= 1'b1;
                        state_r    <= ST_RUN;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MD_TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_MemRead, ex_md_start, md_done, branch_taken;
    logic       mem_RegWrite, wb_RegWrite;

    logic [1:0]  forward_a, forward_b;
    logic        pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble;
    logic        md_timeout;
    logic [31:0] stall_count, flush_count;

    logic [1:0]  s_forward_a, s_forward_b;
    logic        s_pc_write_en, s_if_id_write_en, s_if_id_flush, s_id_ex_bubble, s_ex_hold;
    logic        s_ex_mem_bubble, s_md_timeout;
    logic [2:0]  s_stall_count, s_flush_count;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
        .ex_md_start(ex_md_start), .md_done(md_done), .branch_taken(branch_taken),
        .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
        .forward_a(forward_a), .forward_b(forward_b), .pc_write_en(pc_write_en),
        .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .ex_hold(ex_hold), .ex_mem_bubble(ex_mem_bubble), .md_timeout(md_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter instance to exercise saturation
    pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TO), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
        .ex_md_start(ex_md_start), .md_done(md_done), .branch_taken(branch_taken),
        .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
        .forward_a(s_forward_a), .forward_b(s_forward_b), .pc_write_en(s_pc_write_en),
        .if_id_write_en(s_if_id_write_en), .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble),
        .ex_hold(s_ex_hold), .ex_mem_bubble(s_ex_mem_bubble), .md_timeout(s_md_timeout),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    int checks = 0;
    int failures = 0;

    // Model: mode 0 = normal, 1 = the cycle after a load-use stall, 2 = waiting on mul/div
    int     m_mode;
    int     m_waited;
    bit     m_timeout;
    longint m_stall, m_flush;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (mem_RegWrite && mem_rd != 5'd0 && mem_rd == rs) return 2'b01;
        if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
    endtask

    task automatic set_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_MemRead = 1'b0;
        ex_md_start = 1'b0; md_done = 1'b0; branch_taken = 1'b0;
        mem_rd = 5'd0; mem_RegWrite = 1'b0; wb_rd = 5'd0; wb_RegWrite = 1'b0;
    endtask

    // One clock: check combinational outputs, advance the model, then check registered outputs
    task automatic cycle();
        logic epc, eifid, eflush, ebub, ehold, eexb;
        bit lu;
        #1;
        epc = 1'b1; eifid = 1'b1; eflush = 1'b0; ebub = 1'b0; ehold = 1'b0; eexb = 1'b0;
        lu = ex_MemRead && ex_rd != 5'd0 &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        if (m_mode == 0) begin
            if (branch_taken) begin
                eflush = 1'b1; ebub = 1'b1;
            end else if (ex_md_start && !md_done) begin
                epc = 1'b0; eifid = 1'b0; ehold = 1'b1; eexb = 1'b1;
            end else if (lu) begin
                epc = 1'b0; eifid = 1'b0; ebub = 1'b1;
            end
        end else if (m_mode == 2 && !md_done) begin
            epc = 1'b0; eifid = 1'b0; ehold = 1'b1; eexb = 1'b1;
        end
        chk("forward_a", 64'(forward_a), 64'(exp_fwd(ex_rs1)));
        chk("forward_b", 64'(forward_b), 64'(exp_fwd(ex_rs2)));
        chk("pc_write_en", 64'(pc_write_en), 64'(epc));
        chk("if_id_write_en", 64'(if_id_write_en), 64'(eifid));
        chk("if_id_flush", 64'(if_id_flush), 64'(eflush));
        chk("id_ex_bubble", 64'(id_ex_bubble), 64'(ebub));
        chk("ex_hold", 64'(ex_hold), 64'(ehold));
        chk("ex_mem_bubble", 64'(ex_mem_bubble), 64'(eexb));
        if (rst) begin
            model_reset();
        end else begin
            if (!epc) m_stall = sat(m_stall + 1, 64'hFFFF_FFFF);
            if (eflush) m_flush = sat(m_flush + 1, 64'hFFFF_FFFF);
            case (m_mode)
                0: begin
                    if (branch_taken) m_mode = 0;
                    else if (ex_md_start && !md_done) begin m_mode = 2; m_waited = 0; end
                    else if (lu) m_mode = 1;
                end
                1: m_mode = 0;
                default: begin
                    m_waited++;
                    if (md_done) m_mode = 0;
                    else if (m_waited == MD_TO) begin m_timeout = 1'b1; m_mode = 0; end
                end
            endcase
        end
        @(posedge clk);
        #1;
        chk("md_timeout", 64'(md_timeout), 64'(m_timeout));
        chk("stall_count", 64'(stall_count), 64'(m_stall));
        chk("flush_count", 64'(flush_count), 64'(m_flush));
        chk("stall_count_sat", 64'(s_stall_count), 64'(sat(m_stall, 7)));
        chk("flush_count_sat", 64'(s_flush_count), 64'(sat(m_flush, 7)));
    endtask

    initial begin
        longint base;
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_stall_count", 64'(stall_count), 64'd0);
        chk("rst_md_timeout", 64'(md_timeout), 64'd0);
        cycle();
        rst = 1'b0;

        // Forwarding priority: EX/MEM beats MEM/WB, then MEM/WB alone
        mem_rd = 5'd5; mem_RegWrite = 1'b1; wb_rd = 5'd5; wb_RegWrite = 1'b1;
        ex_rs1 = 5'd5; ex_rs2 = 5'd9;
        cycle();
        chk("t1_fwd_exmem_wins", 64'(forward_a), 64'd1);
        mem_RegWrite = 1'b0; ex_rs2 = 5'd5;
        cycle();
        chk("t1_fwd_memwb", 64'(forward_b), 64'd2);

        // Load-use: one stall cycle then release
        set_idle();
        ex_MemRead = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        cycle();
        set_idle();
        cycle();
        chk("t2_released", 64'(pc_write_en), 64'd1);

        // Branch and load-use together: flush wins, no stall
        ex_MemRead = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1; branch_taken = 1'b1;
        cycle();
        set_idle();
        cycle();

        // Mul/div finishing five cycles after start
        base = m_stall;
        ex_md_start = 1'b1;
        repeat (5) cycle();
        md_done = 1'b1;
        cycle();
        set_idle();
        chk("t4_stall_delta", 64'(stall_count) - 64'(base), 64'd5);
        cycle();

        // Mul/div that never finishes: watchdog fires and stays set
        ex_md_start = 1'b1;
        repeat (MD_TO + 1) cycle();
        chk("t5_timeout_set", 64'(md_timeout), 64'd1);
        set_idle();
        repeat (3) cycle();
        chk("t5_timeout_sticky", 64'(md_timeout), 64'd1);

        // Reset during MD_WAIT, then x0 never forwards or stalls
        ex_md_start = 1'b1;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_idle();
        chk("t6_counters_cleared", 64'(stall_count), 64'd0);
        cycle();
        ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        mem_rd = 5'd0; mem_RegWrite = 1'b1; wb_rd = 5'd0; wb_RegWrite = 1'b1;
        cycle();
        chk("t6_x0_no_fwd", 64'(forward_a), 64'd0);

        // Randomized traffic over a small register range to provoke collisions
        for (int i = 0; i < 400; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
            mem_RegWrite = 1'($urandom_range(0, 1)); wb_RegWrite = 1'($urandom_range(0, 1));
            ex_MemRead   = ($urandom_range(0, 2) == 0);
            ex_md_start  = ($urandom_range(0, 5) == 0);
            md_done      = ($urandom_range(0, 5) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
